mirfak_muldiv: RTL and testbench

Sequential M-extension unit for the Mirfak execute stage: runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on one shared 32-iteration shift/add–subtract datapath. The instruction decoder's `is_m` class (funct3 selects the op) drives `muldiv_valid_i`. This block stalls the pipeline until the result is ready and aborts on pipeline flush. It is instantiated only when `ENABLE_MULTDIV = 1`.

---
 rtl/mirfak_muldiv_pkg.sv | 33 +++
 rtl/mirfak_muldiv_if.sv | 21 ++
 rtl/mirfak_muldiv_dp.sv | 66 ++++++
 rtl/mirfak_muldiv.sv | 114 +++++++++++
 tb/tb_mirfak_muldiv.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mirfak_muldiv_pkg.sv
// rtl/mirfak_muldiv_pkg.sv - shared op encodings, FSM states and constants for the M-extension unit
package mirfak_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int          ITERS        = 32;
    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mirfak_muldiv_if.sv
// rtl/mirfak_muldiv_if.sv - execute-stage request/response bundle for the M-extension unit
interface mirfak_muldiv_if;
    logic        muldiv_valid_i;
    logic [2:0]  muldiv_op_i;
    logic [31:0] muldiv_rs1_i;
    logic [31:0] muldiv_rs2_i;
    logic        muldiv_kill_i;
    logic [31:0] muldiv_result_o;
    logic        muldiv_ready_o;
    logic        muldiv_stall_o;

    modport master (
        output muldiv_valid_i, muldiv_op_i, muldiv_rs1_i, muldiv_rs2_i, muldiv_kill_i,
        input  muldiv_result_o, muldiv_ready_o, muldiv_stall_o
    );

    modport slave (
        input  muldiv_valid_i, muldiv_op_i, muldiv_rs1_i, muldiv_rs2_i, muldiv_kill_i,
        output muldiv_result_o, muldiv_ready_o, muldiv_stall_o
    );
endinterface

// File: rtl/mirfak_muldiv_dp.sv
// rtl/mirfak_muldiv_dp.sv - shared 64-bit shift/add-subtract datapath with sign fix and result select
module mirfak_muldiv_dp
    import mirfak_muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [2:0]  op_i,
    input  logic        neg_i,
    input  logic [31:0] a_mag_i,
    input  logic [31:0] b_mag_i,
    output logic [31:0] result_o
);

    // acc holds {hi, lo}: product accumulator for MUL, {remainder, quotient} for DIV
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [32:0] mul_hi;
    logic [32:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        mul_hi   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_diff = acc_q[63:31] - {1'b0, opnd_q};
        if (load_i) begin
            acc_d  = op_i[2] ? {32'd0, a_mag_i} : {32'd0, b_mag_i};
            opnd_d = op_i[2] ? b_mag_i : a_mag_i;
        end else if (step_i) begin
            if (!op_i[2]) begin
                acc_d = {mul_hi, acc_q[31:1]};
            end else if (div_diff[32]) begin
                acc_d = {acc_q[62:0], 1'b0};
            end else begin
                acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= 64'd0;
            opnd_q <= 32'd0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    always_comb begin
        prod = neg_i ? (~acc_q + 64'd1) : acc_q;
        quo  = neg_i ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem  = neg_i ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        case (op_i)
            OP_MUL:                       result_o = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod[63:32];
            OP_DIV, OP_DIVU:              result_o = quo;
            default:                      result_o = rem;
        endcase
    end

endmodule

// File: rtl/mirfak_muldiv.sv
// rtl/mirfak_muldiv.sv - sequential MUL/DIV/REM unit that stalls EX until its result is ready
module mirfak_muldiv
    import mirfak_muldiv_pkg::*;
#(
    parameter bit ENABLE_MULTDIV = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mirfak_muldiv_if.slave    md
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        dp_load, dp_step;
    logic [31:0] dp_result;
    logic        valid, kill, sa, sb, ready;
    logic [31:0] a, b, a_mag, b_mag;

    assign valid = ENABLE_MULTDIV & md.muldiv_valid_i;
    assign kill  = md.muldiv_kill_i;
    assign a     = md.muldiv_rs1_i;
    assign b     = md.muldiv_rs2_i;
    assign sa    = signed_a(md.muldiv_op_i) & a[31];
    assign sb    = signed_b(md.muldiv_op_i) & b[31];
    assign a_mag = sa ? (~a + 32'd1) : a;
    assign b_mag = sb ? (~b + 32'd1) : b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = result_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid && !kill) begin
                    op_d   = md.muldiv_op_i;
                    sign_d = (md.muldiv_op_i[2] && md.muldiv_op_i[1]) ? sa : (sa ^ sb);
                    cnt_d  = 6'd0;
                    // Divide-by-zero and signed overflow bypass the iteration loop
                    if (md.muldiv_op_i[2] && b == 32'd0) begin
                        result_d = md.muldiv_op_i[1] ? a : DIV_ZERO_Q;
                        state_d  = S_DONE;
                    end else if (md.muldiv_op_i[2] && !md.muldiv_op_i[0] &&
                                 a == INT_MIN && b == 32'hFFFF_FFFF) begin
                        result_d = md.muldiv_op_i[1] ? 32'd0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        dp_load = 1'b1;
                        state_d = md.muldiv_op_i[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'(ITERS - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = dp_result;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d  = S_IDLE;
            cnt_d    = 6'd0;
            result_d = result_q;
            dp_load  = 1'b0;
            dp_step  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    mirfak_muldiv_dp u_dp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .op_i     (dp_load ? md.muldiv_op_i : op_q),
        .neg_i    (sign_q),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .result_o (dp_result)
    );

    assign ready              = ENABLE_MULTDIV & (state_q == S_DONE) & ~kill;
    assign md.muldiv_ready_o  = ready;
    assign md.muldiv_result_o = ENABLE_MULTDIV ? result_q : 32'd0;
    assign md.muldiv_stall_o  = valid & ~ready;

endmodule

// File: tb/tb_mirfak_muldiv.sv
// tb/tb_mirfak_muldiv.sv - directed and randomized checks of mirfak_muldiv against an arithmetic model
module tb_mirfak_muldiv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mirfak_muldiv_if bus ();

    mirfak_muldiv #(.ENABLE_MULTDIV(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .md    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     x, y;
        logic [63:0] p;
        int         sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0, 3'd3: begin x = longint'({32'd0, a}); y = longint'({32'd0, b}); end
            3'd1:       begin x = longint'($signed(a)); y = longint'($signed(b)); end
            3'd2:       begin x = longint'($signed(a)); y = longint'({32'd0, b}); end
            default:    begin x = 0; y = 0; end
        endcase
        p = 64'(x * y);
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called just after a rising edge; leaves valid high so consecutive calls are back-to-back
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] res;
        bit          stall_ok;
        lat = -1;
        res = 32'hDEAD_BEEF;
        stall_ok = 1'b1;
        bus.muldiv_valid_i = 1'b1;
        bus.muldiv_op_i    = op;
        bus.muldiv_rs1_i   = a;
        bus.muldiv_rs2_i   = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.muldiv_ready_o === 1'b1) begin
                lat = c;
                res = bus.muldiv_result_o;
                if (bus.muldiv_stall_o !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (bus.muldiv_stall_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk({tag, "/latency"}, 32'(lat), model_special(op, a, b) ? 32'd1 : 32'd34);
        chk({tag, "/result"}, res, model(op, a, b));
        chk({tag, "/stall"}, {31'd0, stall_ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] edges [5];
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        bit          early_ready;

        edges[0] = 32'd0;
        edges[1] = 32'd1;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h7FFF_FFFF;

        bus.muldiv_valid_i = 1'b0;
        bus.muldiv_op_i    = 3'd0;
        bus.muldiv_rs1_i   = 32'd0;
        bus.muldiv_rs2_i   = 32'd0;
        bus.muldiv_kill_i  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset/result", bus.muldiv_result_o, 32'd0);
        chk("reset/ready", {31'd0, bus.muldiv_ready_o}, 32'd0);
        chk("reset/stall_idle", {31'd0, bus.muldiv_stall_o}, 32'd0);
        bus.muldiv_valid_i = 1'b1;
        #1;
        chk("reset/stall_follows_valid", {31'd0, bus.muldiv_stall_o}, 32'd1);
        bus.muldiv_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 3'd5, 32'd100, 32'd7);
        run_op("remu", 3'd7, 32'd100, 32'd7);
        run_op("divu_zero", 3'd5, 32'd5, 32'd0);
        run_op("rem_zero", 3'd6, 32'h1234_5678, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        bus.muldiv_valid_i = 1'b0;
        @(posedge clk);
        #1;

        // Kill a DIV in its cycle 10, then present a MUL in cycle 11
        early_ready = 1'b0;
        bus.muldiv_valid_i = 1'b1;
        bus.muldiv_op_i    = 3'd4;
        bus.muldiv_rs1_i   = 32'd1000;
        bus.muldiv_rs2_i   = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.muldiv_ready_o !== 1'b0) early_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.muldiv_kill_i = 1'b1;
        @(negedge clk);
        if (bus.muldiv_ready_o !== 1'b0) early_ready = 1'b1;
        chk("kill/no_ready", {31'd0, early_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.muldiv_kill_i = 1'b0;
        run_op("kill/mul_after", 3'd0, 32'd123, 32'd456);
        bus.muldiv_valid_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset in cycle 20 of a MUL
        bus.muldiv_valid_i = 1'b1;
        bus.muldiv_op_i    = 3'd3;
        bus.muldiv_rs1_i   = 32'hDEAD_0001;
        bus.muldiv_rs2_i   = 32'h0BAD_F00D;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.muldiv_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid/result", bus.muldiv_result_o, 32'd0);
        chk("rst_mid/ready", {31'd0, bus.muldiv_ready_o}, 32'd0);
        chk("rst_mid/stall", {31'd0, bus.muldiv_stall_o}, 32'd0);
        @(posedge clk);
        #1;
        run_op("rst_mid/divu_after", 3'd5, 32'hFFFF_FFFF, 32'd10);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end
        bus.muldiv_valid_i = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
